// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter
//   Round-robin arbiter sharing one simple_bus segment between NUM_REQ
//   requesters. Issues a registered one-hot grant, forwards the owner's `a`
//   bit onto the shared bus with one cycle of latency, and inserts a single
//   idle cycle (RELEASE) between consecutive owners.
//
//   Optional feature: define SIMPLE_BUS_ARB_TIMEOUT_EN to compile in the hold
//   counter, the forced-revoke transition after MAX_HOLD grant cycles while
//   another requester is waiting, and the revoke_cnt port.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : per-requester request level
//   done       : per-requester release pulse (owner's bit only)
//   req_a      : per-requester value for bus signal a (owner's bit only)
//   gnt        : registered one-hot grant, zero when no owner
//   gnt_id     : index of the current owner, holds last owner when idle
//   busy       : high while a grant is active
//   bus_a      : registered owner req_a, zero when no owner
//   revoke_cnt : saturating count of forced revokes (timeout build only)

module simple_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [NUM_REQ-1:0] req_a,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               bus_a
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    ,
    output logic [7:0]         revoke_cnt
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("simple_bus_arbiter: NUM_REQ must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("simple_bus_arbiter: MAX_HOLD must be in 1..255");
    end

    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic                 bus_a_q, bus_a_d;

    logic                 any_req;
    logic                 found;
    logic [ID_W-1:0]      win;
    logic                 owner_rel;

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [7:0]           hold_q, hold_d;
    logic [7:0]           revoke_q, revoke_d;
    logic                 others_req;

    assign others_req = |(req & ~gnt_q);
`endif

    assign any_req   = |req;
    // Normal end of tenure: owner drops its request or pulses done.
    assign owner_rel = !req[gnt_id_q] || done[gnt_id_q];

    // Round-robin search starting just after the last owner; the previous
    // owner is therefore examined last and wins only if nobody else asks.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = last_q;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = (32'(last_q) + k) % NREQ_U;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        bus_a_d  = 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        hold_d   = hold_q;
        revoke_d = revoke_q;
`endif
        case (state_q)
            S_IDLE, S_RELEASE: begin
                gnt_d = '0;
                if (any_req && found) begin
                    state_d  = S_GRANT;
                    gnt_id_d = win;
                    last_d   = win;
                    for (int unsigned i = 0; i < NREQ_U; i++) begin
                        gnt_d[i] = (ID_W'(i) == win);
                    end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (owner_rel) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
                end else if (hold_q == HOLD_LIM && others_req) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                    if (revoke_q != 8'hFF) begin
                        revoke_d = revoke_q + 8'd1;
                    end
`endif
                end else begin
                    // bus_a is the owner's req_a registered here, so it
                    // lags req_a by one cycle and is zero on grant/release edges.
                    bus_a_d = req_a[gnt_id_q];
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
                    if (hold_q != HOLD_LIM) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            bus_a_q  <= 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            hold_q   <= '0;
            revoke_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            bus_a_q  <= bus_a_d;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            hold_q   <= hold_d;
            revoke_q <= revoke_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == S_GRANT);
    assign bus_a  = bus_a_q;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    assign revoke_cnt = revoke_q;
`endif

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Testbench for simple_bus_arbiter (NUM_REQ=4, MAX_HOLD=4).
// Stimulus pushes expected post-edge outputs from an ownership model into a
// queue; an independent monitor pops and compares after every clock edge.
// Directed phases add constant checks taken from the arbitration rules.

module tb_simple_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] req_a;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       bus_a;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    logic [7:0] revoke_cnt;
`endif

    simple_bus_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .req_a      (req_a),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .bus_a      (bus_a)
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        ,
        .revoke_cnt (revoke_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       bus_a;
        logic [7:0] rev;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Ownership model: owner index (-1 = nobody), last winner, reported id,
    // cycles held since the grant, forced-revoke count.
    int m_owner, m_last, m_id, m_held, m_rev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [7:0] cur_rev();
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        return revoke_cnt;
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_held  = 0;
        m_rev   = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a);
        exp_t       e;
        logic [3:0] one;
        logic       rel, tmo;
        int         idx;
        one     = 4'b0001;
        e.bus_a = 1'b0;
        if (m_owner >= 0) begin
            rel = !r[m_owner] || d[m_owner];
            tmo = 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            tmo = !rel && (m_held >= MAX_HOLD) && ((r & ~(one << m_owner)) != 4'b0);
`endif
            if (rel || tmo) begin
                if (tmo && m_rev < 255) m_rev++;
                m_owner = -1;
            end else begin
                if (m_held < MAX_HOLD) m_held++;
                e.bus_a = a[m_owner];
            end
        end else if (r != 4'b0) begin
            for (int i = 1; i <= N; i++) begin
                idx = (m_last + i) % N;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_id    = idx;
                    m_held  = 0;
                end
            end
        end
        e.gnt  = (m_owner >= 0) ? (one << m_owner) : 4'b0;
        e.id   = 2'(m_id);
        e.busy = (m_owner >= 0);
        e.rev  = 8'(m_rev);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs (called 2 time units after an edge), record
    // the expected outputs for the coming edge, then advance past that edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a);
        req   = r;
        done  = d;
        req_a = a;
        model_step(r, d, a);
        @(posedge clk);
        #2;
    endtask

    // Asserts reset between edges, checks outputs clear without a clock edge,
    // holds reset over one edge, then releases it with request pattern r.
    task automatic do_reset(input logic [3:0] r);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt",    32'(gnt),    32'd0);
        chk("async_rst_busy",   32'(busy),   32'd0);
        chk("async_rst_bus_a",  32'(bus_a),  32'd0);
        chk("async_rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("async_rst_rev",    32'(cur_rev()), 32'd0);
        sb.delete();
        model_reset();
        req   = r;
        done  = 4'b0;
        req_a = 4'b0;
        @(posedge clk);
        #1;
        chk("rst_held_outputs", 32'({gnt, gnt_id, busy, bus_a}), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every edge that has a queued expectation.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e       = sb.pop_front();
                g.gnt   = gnt;
                g.id    = gnt_id;
                g.busy  = busy;
                g.bus_a = bus_a;
                g.rev   = cur_rev();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL sb_edge t=%0t: got gnt=%b id=%0d busy=%b bus_a=%b rev=%0d want gnt=%b id=%0d busy=%b bus_a=%b rev=%0d",
                             $time, g.gnt, g.id, g.busy, g.bus_a, g.rev,
                             e.gnt, e.id, e.busy, e.bus_a, e.rev);
                end
            end
        end
    end

    initial begin
        logic [3:0] r, d, a, one;
        one   = 4'b0001;
        rst   = 1'b1;
        req   = 4'b1111;
        done  = 4'b0;
        req_a = 4'b0;
        model_reset();

        // Reset held with all requesting: outputs stay zero, then 0 wins first.
        repeat (2) @(posedge clk);
        #1;
        chk("init_rst_outputs", 32'({gnt, gnt_id, busy, bus_a}), 32'd0);
        chk("init_rst_rev", 32'(cur_rev()), 32'd0);
        #1;
        rst = 1'b0;
        cyc(4'b1111, 4'b0, 4'b0);
        chk("first_gnt",    32'(gnt),    32'h1);
        chk("first_gnt_id", 32'(gnt_id), 32'd0);
        chk("first_busy",   32'(busy),   32'd1);

        // Round robin with done after 3 cycles: order 0,1,2,3,0, one gap each.
        for (int k = 0; k < 4; k++) begin
            chk("rr_owner_id",  32'(gnt_id), 32'(k));
            chk("rr_owner_gnt", 32'(gnt),    32'(one << k));
            cyc(4'b1111, 4'b0, 4'b0);
            cyc(4'b1111, 4'b0, 4'b0);
            cyc(4'b1111, one << k, 4'b0);
            chk("rr_gap_gnt",  32'(gnt),  32'd0);
            chk("rr_gap_busy", 32'(busy), 32'd0);
            cyc(4'b1111, 4'b0, 4'b0);
        end
        chk("rr_wrap_id",  32'(gnt_id), 32'd0);
        chk("rr_wrap_gnt", 32'(gnt),    32'h1);

        // Single requester 2 toggling req_a: bus_a follows one cycle later.
        cyc(4'b0000, 4'b0, 4'b0);
        chk("rel0_gnt", 32'(gnt), 32'd0);
        cyc(4'b0100, 4'b0, 4'b0100);
        chk("r2_gnt", 32'(gnt), 32'h4);
        chk("r2_bus_a_grant_edge", 32'(bus_a), 32'd0);
        cyc(4'b0100, 4'b0, 4'b0100);
        chk("r2_bus_a_1", 32'(bus_a), 32'd1);
        cyc(4'b0100, 4'b0, 4'b0000);
        chk("r2_bus_a_0", 32'(bus_a), 32'd0);
        cyc(4'b0100, 4'b0, 4'b0100);
        chk("r2_bus_a_1b", 32'(bus_a), 32'd1);
        cyc(4'b0100, 4'b0100, 4'b0100);
        chk("r2_release_gnt",   32'(gnt),   32'd0);
        chk("r2_release_bus_a", 32'(bus_a), 32'd0);
        cyc(4'b0100, 4'b0, 4'b0100);
        chk("r2_regrant_gnt", 32'(gnt), 32'h4);

        // Requester 1 owns; non-owner req_a[3] and done[3] have no effect.
        cyc(4'b0000, 4'b0, 4'b0);
        cyc(4'b0010, 4'b0, 4'b0);
        chk("r1_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 1) ? 4'b1000 : 4'b0000;
            d = (i == 3) ? 4'b1000 : 4'b0000;
            cyc(4'b0010, d, a);
            chk("r1_nonowner_gnt",   32'(gnt),   32'h2);
            chk("r1_nonowner_bus_a", 32'(bus_a), 32'd0);
        end

        // Requester 0 holds while requester 1 waits.
        cyc(4'b0000, 4'b0, 4'b0);
        cyc(4'b0001, 4'b0, 4'b0);
        chk("hold_r0_gnt", 32'(gnt), 32'h1);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD; i++) begin
            cyc(4'b0011, 4'b0, 4'b0);
            chk("tmo_still_r0", 32'(gnt), 32'h1);
        end
        cyc(4'b0011, 4'b0, 4'b0);
        chk("tmo_revoke_gnt", 32'(gnt), 32'd0);
        chk("tmo_revoke_cnt", 32'(revoke_cnt), 32'd1);
        cyc(4'b0011, 4'b0, 4'b0);
        chk("tmo_next_r1", 32'(gnt), 32'h2);
        for (int i = 0; i < 1700; i++) cyc(4'b0011, 4'b0, 4'b0);
        chk("tmo_revoke_sat", 32'(revoke_cnt), 32'd255);
`else
        for (int i = 0; i < 100; i++) cyc(4'b0011, 4'b0, 4'b0);
        chk("no_tmo_r0_keeps", 32'(gnt), 32'h1);
`endif

        // Reset in the middle of a tenure of requester 2.
        cyc(4'b0000, 4'b0, 4'b0);
        cyc(4'b0000, 4'b0, 4'b0);
        cyc(4'b0100, 4'b0, 4'b0100);
        cyc(4'b0100, 4'b0, 4'b0100);
        chk("pre_rst_gnt",   32'(gnt),   32'h4);
        chk("pre_rst_bus_a", 32'(bus_a), 32'd1);
        do_reset(4'b1111);
        cyc(4'b1111, 4'b0, 4'b0);
        chk("post_rst_r0_first", 32'(gnt), 32'h1);

        // Randomised traffic with sticky requests and sparse done pulses.
        r = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            d = 4'b0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(15) == 0) d[b] = 1'b1;
            end
            a = 4'($urandom);
            cyc(r, d, a);
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
